// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time over valid/ready, WAIT_STATES
// wait cycles, single-cycle response; RAM plus an LED and cycle-counter MMIO window.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] leds
);

  localparam int AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int WLOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam int CW    = (WLOAD > 0) ? $clog2(WLOAD + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] wcnt_q;
  logic          wr_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   cnt_snap_q;
  logic [31:0]   cyc_q;
  logic [31:0]   leds_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic [31:0]   mem_q [DEPTH_WORDS];

  // In IDLE the live request is decoded so WAIT_STATES=0 can respond next cycle;
  // otherwise the latched request is decoded.
  logic          src_wr;
  logic [31:0]   src_addr;
  logic [31:0]   src_cnt;
  logic          dec_mis;
  logic          dec_mmio;
  logic          sel_led;
  logic          sel_cnt;
  logic          sel_ram;
  logic          dec_err;
  logic [AW-1:0] ram_idx;
  logic [31:0]   rdata_d;
  logic [31:0]   leds_d;
  logic          store_commit;

  assign ram_idx = src_addr[AW+1:2];

  always_comb begin
    src_wr   = (state_q == S_IDLE) ? req_write : wr_q;
    src_addr = (state_q == S_IDLE) ? req_addr  : addr_q;
    src_cnt  = (state_q == S_IDLE) ? cyc_q     : cnt_snap_q;

    dec_mis  = src_addr[1:0] != 2'b00;
    dec_mmio = src_addr[31:16] == MMIO_BASE[31:16];
    sel_led  = !dec_mis && dec_mmio && (src_addr[15:0] == 16'h0000);
    sel_cnt  = !dec_mis && dec_mmio && (src_addr[15:0] == 16'h0004);
    sel_ram  = !dec_mis && !dec_mmio &&
               ({2'b00, src_addr[31:2]} < 32'(DEPTH_WORDS));
    dec_err  = !(sel_led || sel_cnt || sel_ram) || (sel_cnt && src_wr);

    rdata_d = '0;
    if (!dec_err && !src_wr) begin
      if (sel_ram)      rdata_d = mem_q[ram_idx];
      else if (sel_led) rdata_d = leds_q;
      else if (sel_cnt) rdata_d = src_cnt;
    end

    leds_d = leds_q;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) leds_d[8*i +: 8] = wdata_q[8*i +: 8];
    end

    store_commit = (state_q == S_RESP) && wr_q && !rsp_err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      leds_q      <= '0;
      cyc_q       <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            wr_q        <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_snap_q  <= cyc_q;
            req_ready_q <= 1'b0;
            if (WAIT_STATES > 0) begin
              state_q <= S_WAIT;
              wcnt_q  <= CW'(WLOAD);
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_d;
              rsp_err_q   <= dec_err;
            end
          end
        end
        S_WAIT: begin
          if (wcnt_q == '0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= dec_err;
          end else begin
            wcnt_q <= wcnt_q - CW'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          if (store_commit && sel_led) leds_q <= leds_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM has no reset; stores commit on the edge leaving RESP.
  always_ff @(posedge clk) begin
    if (!reset && store_commit && sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[ram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, randomized traffic against a
// word/byte-level memory model, reset corners, and a zero-wait-state instance.
module tb_dmem_responder;

  localparam int          DW = 256;
  localparam int          WS = 1;
  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata, leds;
  logic [3:0]  req_be;
  logic        req_valid0, req_write0, req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0, leds0;
  logic [3:0]  req_be0;

  dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS), .MMIO_BASE(MB)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .leds(leds));

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .MMIO_BASE(MB)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_write(req_write0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .leds(leds0));

  int checks = 0;
  int errors = 0;

  // Reference cycle count: cycles elapsed since reset released.
  logic [31:0] tb_cyc;
  always @(posedge clk) tb_cyc <= reset ? 32'd0 : tb_cyc + 32'd1;

  logic [31:0] mem_m [DW];
  logic [31:0] leds_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // idle cycle that follows the response.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd,
                        output logic er, output logic [31:0] snap);
    int  n;
    bit  got;
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
    snap = tb_cyc;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom % 2);
    req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    n = 1; got = 0; rd = '0; er = 1'b0;
    while (!got && n <= 20) begin
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err;
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
      end else begin
        chk("rdata_when_idle", rsp_rdata, 32'd0);
        chk("err_when_idle", {31'd0, rsp_err}, 32'd0);
        chk("ready_while_busy", {31'd0, req_ready}, 32'd0);
        n++;
        @(negedge clk);
      end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL rsp_timeout actual=none required=rsp_valid addr=%h", a);
    end else begin
      chk("latency", 32'(n), 32'(1 + WS));
    end
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  // Behavioural model from the address map rules; updates state on a good store.
  task automatic ref_model(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] snap,
                           output logic [31:0] rd, output logic er);
    logic [31:0] off;
    rd = '0; er = 1'b0;
    off = a & 32'h0000_FFFF;
    if (a % 4 != 0) er = 1'b1;
    else if ((a >> 16) == (MB >> 16)) begin
      if (off == 0) begin
        if (w) begin
          for (int i = 0; i < 4; i++) if (be[i]) leds_m[8*i +: 8] = d[8*i +: 8];
        end else rd = leds_m;
      end else if (off == 4) begin
        if (w) er = 1'b1; else rd = snap;
      end else er = 1'b1;
    end else if (a / 4 < DW) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (be[i]) mem_m[a/4][8*i +: 8] = d[8*i +: 8];
      end else rd = mem_m[a/4];
    end else er = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    int          k;
    logic [31:0] wi;
    k  = $urandom_range(0, 7);
    wi = 32'($urandom_range(0, 63));
    case (k)
      0, 1, 2, 3: return wi << 2;
      4:          return (wi << 2) | 32'($urandom_range(1, 3));
      5:          return ($urandom_range(0, 1) == 0) ? 32'(4 * DW) + (wi << 2) : 32'h8000_0000;
      6: begin
        case ($urandom_range(0, 3))
          0:       return MB;
          1:       return MB + 32'h8;
          2:       return MB + 32'h10;
          default: return MB + 32'hFFFC;
        endcase
      end
      default:    return MB + 32'h4;
    endcase
  endfunction

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] erd;
    logic        eer;
    logic [31:0] eleds;
  } vec_t;

  vec_t tv [18];

  initial begin
    logic [31:0] rd, erd, snap, a, d, ca, cb;
    logic        er, eer, w;
    logic [3:0]  be;

    tv[0]  = '{1'b1, 32'h10,      32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 32'h0};
    tv[1]  = '{1'b0, 32'h10,      32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[2]  = '{1'b1, 32'h20,      32'h11223344, 4'hF, 32'h0,        1'b0, 32'h0};
    tv[3]  = '{1'b1, 32'h20,      32'hAABBCCDD, 4'h5, 32'h0,        1'b0, 32'h0};
    tv[4]  = '{1'b0, 32'h20,      32'h0,        4'hF, 32'h11BB33DD, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 32'h20,      32'hFFFFFFFF, 4'h0, 32'h0,        1'b0, 32'h0};
    tv[6]  = '{1'b0, 32'h20,      32'h0,        4'h0, 32'h11BB33DD, 1'b0, 32'h0};
    tv[7]  = '{1'b0, 32'h22,      32'h0,        4'hF, 32'h0,        1'b1, 32'h0};
    tv[8]  = '{1'b0, 32'h400,     32'h0,        4'hF, 32'h0,        1'b1, 32'h0};
    tv[9]  = '{1'b1, MB + 32'h4,  32'h1,        4'hF, 32'h0,        1'b1, 32'h0};
    tv[10] = '{1'b0, MB + 32'h8,  32'h0,        4'hF, 32'h0,        1'b1, 32'h0};
    tv[11] = '{1'b1, 32'h22,      32'h12345678, 4'hF, 32'h0,        1'b1, 32'h0};
    tv[12] = '{1'b0, 32'h20,      32'h0,        4'hF, 32'h11BB33DD, 1'b0, 32'h0};
    tv[13] = '{1'b0, MB,          32'h0,        4'hF, 32'h0,        1'b0, 32'h0};
    tv[14] = '{1'b1, MB,          32'h000000A5, 4'hF, 32'h0,        1'b0, 32'hA5};
    tv[15] = '{1'b0, MB,          32'h0,        4'h0, 32'hA5,       1'b0, 32'hA5};
    tv[16] = '{1'b1, 32'h400,     32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 32'hA5};
    tv[17] = '{1'b0, 32'h10,      32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 32'hA5};

    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; req_be0 = 0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rdata", rsp_rdata, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_leds", leds, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      do_req(tv[i].w, tv[i].a, tv[i].d, tv[i].be, rd, er, snap);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].erd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tv[i].eer});
      chk($sformatf("vec%0d_leds", i), leds, tv[i].eleds);
    end
    leds_m = 32'hA5;

    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      do_req(1'b1, 32'(i * 4), d, 4'hF, rd, er, snap);
      ref_model(1'b1, 32'(i * 4), d, 4'hF, snap, erd, eer);
      chk("fill_err", {31'd0, er}, {31'd0, eer});
    end

    do_req(1'b0, MB + 32'h4, 32'h0, 4'hF, ca, er, snap);
    chk("counter_abs", ca, snap);
    repeat (7) @(negedge clk);
    do_req(1'b0, MB + 32'h4, 32'h0, 4'hF, cb, er, snap);
    chk("counter_delta10", cb - ca, 32'd10);

    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom % 2); a = rand_addr(); d = $urandom; be = 4'($urandom);
      do_req(w, a, d, be, rd, er, snap);
      ref_model(w, a, d, be, snap, erd, eer);
      chk($sformatf("rand%0d_rdata_a%h", i, a), rd, erd);
      chk($sformatf("rand%0d_err_a%h", i, a), {31'd0, er}, {31'd0, eer});
      chk($sformatf("rand%0d_leds", i), leds, leds_m);
    end

    // Reset while a store to 0x30 is in its wait state.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_wait_busy", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    leds_m = 32'h0;
    chk("rst_wait_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wait_leds", leds, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_wait_quiet", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 32'h30, 32'h0, 4'hF, rd, er, snap);
    chk("rst_wait_mem_kept", rd, mem_m[12]);

    // Reset and request together: request must not be accepted.
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h0; req_be = 4'hF;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    chk("rst_req_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_req_ready2", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h30, 32'h0, 4'hF, rd, er, snap);
    chk("rst_req_mem_kept", rd, mem_m[12]);

    // Zero wait states, req_valid held: store to LED then back-to-back loads.
    req_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_write0 = (i == 0); req_addr0 = MB; req_wdata0 = 32'h3C; req_be0 = 4'hF;
      chk($sformatf("ws0_ready%0d", i), {31'd0, req_ready0}, {31'd0, (i % 2 == 0)});
      chk($sformatf("ws0_valid%0d", i), {31'd0, rsp_valid0}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) begin
        chk($sformatf("ws0_rdata%0d", i), rsp_rdata0, (i == 1) ? 32'h0 : 32'h3C);
        chk($sformatf("ws0_err%0d", i), {31'd0, rsp_err0}, 32'd0);
      end
      @(negedge clk);
    end
    req_valid0 = 1'b0;
    chk("ws0_leds", leds0, 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
